// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: pops PS/2 scan bytes from the receiver FIFO and decodes make/break/modifier state
module ps2_scan_decoder #(
    parameter int CNT_W         = 8,
    parameter bit IGNORE_REPEAT = 1'b1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             ready,
    input  logic [7:0]       data,
    input  logic             overflow,
    output logic             nextdata_n,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_down,
    output logic             make_pulse,
    output logic             break_pulse,
    output logic [CNT_W-1:0] press_count,
    output logic             shift,
    output logic             ctrl,
    output logic             caps_lock,
    output logic             ovf_seen
);

    typedef enum logic [1:0] {WAIT, POP, DECODE} state_t;

    state_t     state;
    logic [7:0] byte_r;
    logic       ext_f, brk_f;
    logic       sh_l, sh_r, ct_l, ct_r;
    logic [8:0] held_r;
    logic [8:0] code;
    logic       is_rep;

    // Prefix-qualified code of the latched byte and typematic-repeat detection against the held key
    always_comb begin
        code   = {ext_f, byte_r};
        is_rep = IGNORE_REPEAT && key_down && (code == held_r);
    end

    assign shift = sh_l | sh_r;
    assign ctrl  = ct_l | ct_r;

    // Handshake FSM with byte decode; overflow is applied last so it overrides prefix latching
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= WAIT;
            nextdata_n  <= 1'b1;
            byte_r      <= 8'h00;
            ext_f       <= 1'b0;
            brk_f       <= 1'b0;
            held_r      <= 9'h000;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_down    <= 1'b0;
            make_pulse  <= 1'b0;
            break_pulse <= 1'b0;
            press_count <= '0;
            sh_l        <= 1'b0;
            sh_r        <= 1'b0;
            ct_l        <= 1'b0;
            ct_r        <= 1'b0;
            caps_lock   <= 1'b0;
            ovf_seen    <= 1'b0;
        end else begin
            make_pulse  <= 1'b0;
            break_pulse <= 1'b0;
            case (state)
                WAIT: if (ready) begin
                    byte_r     <= data;
                    nextdata_n <= 1'b0;
                    state      <= POP;
                end
                POP: begin
                    nextdata_n <= 1'b1;
                    state      <= DECODE;
                end
                default: begin
                    state <= WAIT;
                    if (byte_r == 8'hE0) ext_f <= 1'b1;
                    else if (byte_r == 8'hF0) brk_f <= 1'b1;
                    else begin
                        ext_f <= 1'b0;
                        brk_f <= 1'b0;
                        if (byte_r != 8'h00 && byte_r != 8'hFF) begin
                            if (brk_f) begin
                                key_code    <= byte_r;
                                key_ext     <= ext_f;
                                break_pulse <= 1'b1;
                                if (code == held_r) key_down <= 1'b0;
                            end else if (!is_rep) begin
                                key_code    <= byte_r;
                                key_ext     <= ext_f;
                                key_down    <= 1'b1;
                                held_r      <= code;
                                make_pulse  <= 1'b1;
                                press_count <= press_count + CNT_W'(1);
                                if (code == 9'h058) caps_lock <= ~caps_lock;
                            end
                            if (brk_f || !is_rep) begin
                                if (code == 9'h012) sh_l <= !brk_f;
                                if (code == 9'h059) sh_r <= !brk_f;
                                if (code == 9'h014) ct_l <= !brk_f;
                                if (code == 9'h114) ct_r <= !brk_f;
                            end
                        end
                    end
                end
            endcase
            if (overflow) begin
                ovf_seen <= 1'b1;
                ext_f    <= 1'b0;
                brk_f    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb_ps2_scan_decoder: directed self-checking bench for the PS/2 scan decoder
module tb_ps2_scan_decoder;

    logic       clk = 1'b0;
    logic       clrn = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data = 8'h00;
    logic       overflow = 1'b0;

    logic       nextdata_n, key_ext, key_down, make_pulse, break_pulse, shift, ctrl, caps_lock, ovf_seen;
    logic [7:0] key_code, press_count;
    logic       nextdata_n1, key_ext1, key_down1, make_pulse1, break_pulse1, shift1, ctrl1, caps_lock1, ovf_seen1;
    logic [7:0] key_code1, press_count1;

    int checks = 0;
    int failures = 0;
    int pop_cnt = 0;
    int make_cnt = 0;
    int p0, m0;

    always #5 clk = ~clk;

    ps2_scan_decoder #(.CNT_W(8), .IGNORE_REPEAT(1'b1)) dut (
        .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
        .nextdata_n(nextdata_n), .key_code(key_code), .key_ext(key_ext), .key_down(key_down),
        .make_pulse(make_pulse), .break_pulse(break_pulse), .press_count(press_count),
        .shift(shift), .ctrl(ctrl), .caps_lock(caps_lock), .ovf_seen(ovf_seen)
    );

    ps2_scan_decoder #(.CNT_W(8), .IGNORE_REPEAT(1'b0)) dut_rep (
        .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
        .nextdata_n(nextdata_n1), .key_code(key_code1), .key_ext(key_ext1), .key_down(key_down1),
        .make_pulse(make_pulse1), .break_pulse(break_pulse1), .press_count(press_count1),
        .shift(shift1), .ctrl(ctrl1), .caps_lock(caps_lock1), .ovf_seen(ovf_seen1)
    );

    // Count cycles with the pop strobe low and cycles with a make pulse
    always @(negedge clk) begin
        if (nextdata_n === 1'b0) pop_cnt++;
        if (make_pulse === 1'b1) make_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pop();
        int t = 0;
        while (nextdata_n !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            checks++;
            failures++;
            $error("FAIL pop_timeout observed=%0h expected=%0h", nextdata_n, 1'b0);
        end
    endtask

    // Present one byte, wait for its pop, return at the negedge where the decode pulses are visible
    task automatic send(input logic [7:0] b);
        data  = b;
        ready = 1'b1;
        wait_pop();
        ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        clrn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_nextdata_n", nextdata_n, 1);
        chk("rst_key_code", key_code, 0);
        chk("rst_key_ext", key_ext, 0);
        chk("rst_key_down", key_down, 0);
        chk("rst_make", make_pulse, 0);
        chk("rst_break", break_pulse, 0);
        chk("rst_count", press_count, 0);
        chk("rst_shift", shift, 0);
        chk("rst_ctrl", ctrl, 0);
        chk("rst_caps", caps_lock, 0);
        chk("rst_ovf", ovf_seen, 0);
        clrn = 1'b1;
        @(negedge clk);

        // Basic make and break of 1C
        p0 = pop_cnt;
        m0 = make_cnt;
        send(8'h1C);
        chk("mk_pulse", make_pulse, 1);
        chk("mk_code", key_code, 8'h1C);
        chk("mk_down", key_down, 1);
        chk("mk_count", press_count, 1);
        send(8'hF0);
        chk("f0_no_make", make_pulse, 0);
        chk("f0_no_break", break_pulse, 0);
        send(8'h1C);
        chk("brk_pulse", break_pulse, 1);
        chk("brk_down", key_down, 0);
        chk("brk_code", key_code, 8'h1C);
        chk("pop_cycles", pop_cnt - p0, 3);
        chk("make_total", make_cnt - m0, 1);

        // Typematic repeats
        do_reset();
        m0 = make_cnt;
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        chk("rep_count_ign", press_count, 1);
        chk("rep_make_ign", make_cnt - m0, 1);
        chk("rep_count_all", press_count1, 3);
        chk("rep_down", key_down, 0);

        // Modifiers
        do_reset();
        send(8'hE0); send(8'h14);
        chk("ctr_ctrl", ctrl, 1);
        chk("ctr_ext", key_ext, 1);
        chk("ctr_code", key_code, 8'h14);
        send(8'hE0); send(8'hF0); send(8'h14);
        chk("ctr_rel", ctrl, 0);
        chk("ctr_rel_break", break_pulse, 1);
        send(8'h12);
        chk("shl_on", shift, 1);
        send(8'hF0); send(8'h12);
        chk("shl_off", shift, 0);
        send(8'hE0); send(8'h12);
        chk("e012_shift", shift, 0);
        chk("e012_ext", key_ext, 1);
        send(8'hE0); send(8'hFF); send(8'h14);
        chk("err_clr_ext", key_ext, 0);
        chk("err_ctl", ctrl, 1);
        send(8'hF0); send(8'h14);
        chk("ctl_off", ctrl, 0);

        // Caps lock and rollover
        do_reset();
        send(8'h58);
        chk("caps_on", caps_lock, 1);
        send(8'hF0); send(8'h58); send(8'h58);
        chk("caps_off", caps_lock, 0);
        send(8'hF0); send(8'h58);
        chk("caps_count", press_count, 2);
        send(8'h1C); send(8'h32); send(8'hF0); send(8'h1C);
        chk("roll_break", break_pulse, 1);
        chk("roll_down", key_down, 1);
        chk("roll_code", key_code, 8'h1C);
        send(8'hF0); send(8'h32);
        chk("roll_rel_down", key_down, 0);
        chk("roll_rel_code", key_code, 8'h32);

        // Counter wrap
        do_reset();
        for (int i = 0; i < 255; i++) begin
            send(8'h1C); send(8'hF0); send(8'h1C);
        end
        chk("wrap_pre", press_count, 255);
        send(8'h1C);
        chk("wrap_zero", press_count, 0);
        chk("wrap_make", make_pulse, 1);

        // Reset during POP, re-fetch, overflow
        do_reset();
        send(8'h12);
        chk("pre_shift", shift, 1);
        data  = 8'h1C;
        ready = 1'b1;
        wait_pop();
        clrn = 1'b0;
        #1;
        chk("abort_nextdata_n", nextdata_n, 1);
        chk("abort_shift", shift, 0);
        chk("abort_count", press_count, 0);
        chk("abort_down", key_down, 0);
        chk("abort_code", key_code, 0);
        @(negedge clk);
        clrn = 1'b1;
        p0 = pop_cnt;
        m0 = make_cnt;
        wait_pop();
        ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("refetch_make", make_pulse, 1);
        chk("refetch_code", key_code, 8'h1C);
        chk("refetch_count", press_count, 1);
        repeat (3) @(negedge clk);
        chk("refetch_pops", pop_cnt - p0, 1);
        chk("refetch_makes", make_cnt - m0, 1);
        send(8'hE0);
        overflow = 1'b1;
        @(negedge clk);
        overflow = 1'b0;
        chk("ovf_set", ovf_seen, 1);
        send(8'h14);
        chk("ovf_clr_ext", key_ext, 0);
        chk("ovf_sticky", ovf_seen, 1);
        do_reset();
        chk("ovf_reset", ovf_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
Downstream consumer of the ps2_keyboard receiver FIFO. It pops scan-code bytes through the ready/nextdata_n handshake and interprets the E0 (extended) and F0 (break) prefixes. It tracks the currently held key, modifier state and the number of distinct key presses, and emits single-cycle make/break events. Its outputs drive the scan-to-ASCII and seven-segment display stages.

Parameters:
CNT_W, 8, width of press_count; wraps modulo 2^CNT_W.
IGNORE_REPEAT, 1, 1 = typematic repeats of the held key neither count nor pulse make_pulse; 0 = every make code counts.

Ports:
clk  in  1  system clock; all state on rising edge.
clrn  in  1  asynchronous, active-low reset.
ready  in  1  FIFO non-empty; data valid while high.
data  in  8  FIFO head byte.
overflow  in  1  FIFO overflow flag from the receiver.
nextdata_n  out  1  active-low pop strobe, registered, low exactly one cycle per byte.
key_code  out  8  last make/break code, prefix stripped.
key_ext  out  1  key_code came with an E0 prefix.
key_down  out  1  held key (key_code/key_ext) is currently pressed.
make_pulse  out  1  one-cycle pulse on a counted key press.
break_pulse  out  1  one-cycle pulse on any key release.
press_count  out  CNT_W  number of counted presses.
shift  out  1  left (12) or right (59) shift is held.
ctrl  out  1  left (14) or right (E0 14) ctrl is held.
caps_lock  out  1  toggles on each counted press of 58.
ovf_seen  out  1  sticky; set when overflow is observed.

Behaviour:
- Reset (clrn low, asynchronous): nextdata_n=1. All other outputs are 0, as are the internal ext_f, brk_f, byte latch and shift-L/R / ctrl-L/R flags. State=WAIT. A reset in the middle of a handshake aborts it; no pop is issued.
- Handshake FSM, one byte per 3 cycles minimum:
  - WAIT: when ready=1, latch data into byte_r, drive nextdata_n<=0, go to POP.
  - POP: nextdata_n is low this cycle, so the FIFO pops at this edge. Drive nextdata_n<=1, go to DECODE.
  - DECODE: process byte_r as below, return to WAIT. ready is not sampled in POP or DECODE.
- Decode of byte_r:
  - E0: ext_f<=1. F0: brk_f<=1. Neither prefix produces a pulse.
  - 00 or FF (error codes): discard the byte and clear ext_f and brk_f.
  - Any other byte b, with code={ext_f,b}:
    - brk_f=1 (release): key_code<=b, key_ext<=ext_f, break_pulse=1. If code equals the held code, key_down<=0; otherwise key_down is unchanged. The matching modifier flag clears.
    - brk_f=0 (make): if key_down=1, code equals the held code and IGNORE_REPEAT=1, it is a repeat and has no effect. Otherwise: key_code<=b, key_ext<=ext_f, key_down<=1, make_pulse=1, press_count+1 (wrapping). The modifier flag sets. Code 58 toggles caps_lock (the E0 form does not).
    - ext_f and brk_f clear after any non-prefix byte.
- Modifier mapping: shift = shL|shR. ctrl = ctL|ctR. ctL is {0,14}; ctR is {1,14}. E0 12 and E0 59 are not shift.
- make_pulse and break_pulse are high for exactly the DECODE+1 cycle (registered).
- Rollover: a newer make replaces the held code. Releasing a non-held key only pulses break_pulse.
- overflow=1 on any cycle: ovf_seen<=1 (sticky until reset), and ext_f/brk_f clear. Decoding otherwise continues.
- Simultaneous overflow with a prefix byte in DECODE: the overflow clear wins.

Test Plan:
- Reset, then FIFO bytes 1C, F0, 1C: one make_pulse with key_code=1C and key_down=1, press_count=1. Then break_pulse with key_down=0 and key_code=1C. nextdata_n goes low exactly 3 times, each for 1 cycle.
- Bytes 1C,1C,1C,F0,1C (typematic) with IGNORE_REPEAT=1: press_count=1 and one make_pulse. With IGNORE_REPEAT=0: press_count=3.
- Bytes E0,14 then E0,F0,14: ctrl=1 with key_ext=1 and key_code=14, then ctrl=0. Byte 12 alone gives shift=1; E0,12 leaves shift=0.
- Bytes 58,F0,58,58,F0,58: caps_lock goes 1 then 0, press_count=2. 1C,32,F0,1C: key_down stays 1 with key_code=1C at the F0 1C break_pulse. Releasing the held key 32 then gives key_down=0.
- press_count preloaded to 255 via 255 press/release pairs, then one more press: press_count=0 (wrap).
- clrn pulsed low while in POP with ready held high: all outputs 0 and nextdata_n=1 immediately. After release, the still-present head byte is re-fetched and decoded once. overflow pulse in between: ovf_seen=1 and stays 1.
